// File: rtl/writeback.sv
// Write-back stage.
// Joins each in-order instruction record from the dispatcher FIFO with the
// result beats of the execution units it was issued to. Emits one register-file
// write / forwarding beat per committed record. Raises a one-cycle redirect and
// flush pulse on taken branches and system redirects.
module writeback #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,

  // Instruction records from the dispatcher FIFO
  input  logic              exwb_tvalid,
  output logic              exwb_tready,
  input  logic [4:0]        exwb_rd,
  input  logic              exwb_rd_vld,
  input  logic              exwb_alu_cmd_vld,
  input  logic              exwb_bru_cmd_vld,
  input  logic              exwb_sys_cmd_vld,

  // ALU result
  input  logic              alu_tvalid,
  output logic              alu_tready,
  input  logic [XLEN-1:0]   alu_tdata,

  // BRU result {taken, target, link}
  input  logic              bru_tvalid,
  output logic              bru_tready,
  input  logic [2*XLEN:0]   bru_tdata,

  // SYS result {redirect, target, wdata}
  input  logic              sys_tvalid,
  output logic              sys_tready,
  input  logic [2*XLEN:0]   sys_tdata,

  // Register-file write / forwarding beat {wdata, rd, we}
  output logic              wbrf_tvalid,
  input  logic              wbrf_tready,
  output logic [XLEN+5:0]   wbrf_tdata,

  // Pipeline redirect and flush
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              invalidate
);

  localparam int NUM_UNITS = 3;
  localparam int UNIT_ALU  = 0;
  localparam int UNIT_BRU  = 1;
  localparam int UNIT_SYS  = 2;

  // Per-unit handshake and slot bookkeeping, indexed by UNIT_*
  logic [NUM_UNITS-1:0] unit_tvalid;
  logic [NUM_UNITS-1:0] unit_tready;
  logic [NUM_UNITS-1:0] cmd_vld;
  logic [NUM_UNITS-1:0] capture;
  logic [NUM_UNITS-1:0] slot_valid_reg;

  // Slot payloads
  logic [XLEN-1:0]      alu_data_reg;
  logic [2*XLEN:0]      bru_data_reg;
  logic [2*XLEN:0]      sys_data_reg;

  // Output registers
  logic                 wbrf_tvalid_reg;
  logic [XLEN+5:0]      wbrf_tdata_reg;
  logic                 redirect_valid_reg;
  logic [XLEN-1:0]      redirect_pc_reg;
  logic                 invalidate_reg;

  // Join / commit
  logic                 join_ok;
  logic                 out_free;
  logic                 commit;

  // Decoded slot fields
  logic                 bru_taken;
  logic [XLEN-1:0]      bru_target;
  logic [XLEN-1:0]      bru_link;
  logic                 sys_redirect;
  logic [XLEN-1:0]      sys_target;
  logic [XLEN-1:0]      sys_wdata;

  // Next values for the output registers
  logic                 take_redirect;
  logic [XLEN-1:0]      redirect_pc_next;
  logic [XLEN-1:0]      wdata_next;
  logic                 we_next;

  assign unit_tvalid = {sys_tvalid, bru_tvalid, alu_tvalid};
  assign cmd_vld     = {exwb_sys_cmd_vld, exwb_bru_cmd_vld, exwb_alu_cmd_vld};

  assign alu_tready  = unit_tready[UNIT_ALU];
  assign bru_tready  = unit_tready[UNIT_BRU];
  assign sys_tready  = unit_tready[UNIT_SYS];

  // One holding slot per unit. A unit is only accepted into an empty slot and
  // never during a flush cycle, so the slot always belongs to the oldest record
  // that still needs that unit.
  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slot
      assign unit_tready[gi] = !rst && !slot_valid_reg[gi] && !invalidate_reg;
      assign capture[gi]     = unit_tvalid[gi] && unit_tready[gi];

      // Slot occupancy: cleared by reset, flush or a commit that consumes it.
      always_ff @(posedge clk) begin
        if (rst || invalidate_reg) begin
          slot_valid_reg[gi] <= 1'b0;
        end else if (commit && cmd_vld[gi]) begin
          slot_valid_reg[gi] <= 1'b0;
        end else if (capture[gi]) begin
          slot_valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // ALU slot payload, loaded on capture only.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_data_reg <= '0;
    end else if (capture[UNIT_ALU]) begin
      alu_data_reg <= alu_tdata;
    end
  end

  // BRU slot payload, loaded on capture only.
  always_ff @(posedge clk) begin
    if (rst) begin
      bru_data_reg <= '0;
    end else if (capture[UNIT_BRU]) begin
      bru_data_reg <= bru_tdata;
    end
  end

  // SYS slot payload, loaded on capture only.
  always_ff @(posedge clk) begin
    if (rst) begin
      sys_data_reg <= '0;
    end else if (capture[UNIT_SYS]) begin
      sys_data_reg <= sys_tdata;
    end
  end

  assign bru_taken    = bru_data_reg[2*XLEN];
  assign bru_target   = bru_data_reg[2*XLEN-1:XLEN];
  assign bru_link     = bru_data_reg[XLEN-1:0];
  assign sys_redirect = sys_data_reg[2*XLEN];
  assign sys_target   = sys_data_reg[2*XLEN-1:XLEN];
  assign sys_wdata    = sys_data_reg[XLEN-1:0];

  // Only registered slot contents count: a unit beat arriving in the same
  // cycle as the record is seen one cycle later, which keeps the join path
  // free of unit-to-output combinational paths.
  assign join_ok  = exwb_tvalid && (&(~cmd_vld | slot_valid_reg));
  assign out_free = !wbrf_tvalid_reg || wbrf_tready;
  assign commit   = join_ok && out_free && !invalidate_reg && !rst;

  assign exwb_tready = commit;

  // Result selection and redirect decision for the record at the FIFO head.
  always_comb begin
    wdata_next       = alu_data_reg;
    redirect_pc_next = bru_target;
    take_redirect    = 1'b0;
    we_next          = exwb_rd_vld && (exwb_rd != 5'd0);

    if (exwb_sys_cmd_vld) begin
      wdata_next = sys_wdata;
    end else if (exwb_bru_cmd_vld) begin
      wdata_next = bru_link;
    end

    // SYS wins over BRU when both want to redirect.
    if (exwb_sys_cmd_vld && sys_redirect) begin
      take_redirect    = 1'b1;
      redirect_pc_next = sys_target;
    end else if (exwb_bru_cmd_vld && bru_taken) begin
      take_redirect    = 1'b1;
      redirect_pc_next = bru_target;
    end
  end

  // Write-back beat register: loads on commit, holds until accepted. A flush
  // cycle never commits, so an already-retired beat is still delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbrf_tvalid_reg <= 1'b0;
      wbrf_tdata_reg  <= '0;
    end else if (commit) begin
      wbrf_tvalid_reg <= 1'b1;
      wbrf_tdata_reg  <= {wdata_next, exwb_rd, we_next};
    end else if (wbrf_tready) begin
      wbrf_tvalid_reg <= 1'b0;
    end
  end

  // Redirect and flush pulses, aligned with the committing write-back beat.
  // The flush blocks the next commit, so both pulses last a single cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_reg <= 1'b0;
      invalidate_reg     <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      redirect_valid_reg <= commit && take_redirect;
      invalidate_reg     <= commit && take_redirect;
      if (commit && take_redirect) begin
        redirect_pc_reg <= redirect_pc_next;
      end
    end
  end

  assign wbrf_tvalid    = wbrf_tvalid_reg;
  assign wbrf_tdata     = wbrf_tdata_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign invalidate     = invalidate_reg;

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
Write-back stage directly downstream of the instruction dispatcher and the ALU/BRU/System execution units. It joins each in-order instruction record leaving the dispatcher FIFO with the result beats of the units that instruction was issued to. It then emits one register-file write / forwarding beat per instruction. It also raises the pipeline redirect and the `invalidate` flush on taken branches and system redirects (traps, xRET).

Parameters:
XLEN, offnariscv_pkg::XLEN, datapath width (informational; taken from the package).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
exwb_axis_if  axis_if.s  $bits(exwb_tdata_t)  instruction records from the dispatcher FIFO. Fields used: rf_data.id_data.{rd[4:0], rd_vld, alu_cmd_vld, bru_cmd_vld, sys_cmd_vld}.
alu_axis_if  axis_if.s  XLEN  ALU result.
bru_axis_if  axis_if.s  1+2*XLEN  {taken, target[XLEN], link[XLEN]}.
sys_axis_if  axis_if.s  1+2*XLEN  {redirect, target[XLEN], wdata[XLEN]}.
wbrf_axis_if  axis_if.m  $bits(wbrf_tdata_t)  {wdata[XLEN], rd[4:0], we}; register-file write and dispatcher forwarding source.
redirect_valid  out  1  one-cycle pulse; fetch restarts at redirect_pc.
redirect_pc  out  XLEN  redirect target.
invalidate  out  1  one-cycle flush pulse to the dispatcher FIFO and upstream stages.

Behaviour:
- Reset: all slot valid bits 0. wbrf tvalid=0, wbrf tdata=0, redirect_valid=0, redirect_pc=0, invalidate=0. All input treadys are 0 during rst=1.
- Result slots: three one-entry holding slots (ALU, BRU, SYS), each with a valid bit.
  - Unit tready = !slot_valid && !invalidate.
  - A slot captures on tvalid&&tready.
- Units return results in issue order, at most one outstanding per unit. The slot therefore always belongs to the oldest exwb record needing that unit.
- Join condition: `join_ok` = exwb tvalid && (!alu_cmd_vld || alu_slot_valid) && (!bru_cmd_vld || bru_slot_valid) && (!sys_cmd_vld || sys_slot_valid).
  - A beat arriving in the same cycle is not bypassed. It is visible one cycle later.
- Commit = join_ok && (!wbrf tvalid || wbrf tready) && !invalidate.
  - exwb tready = commit.
  - On commit, the used slots are cleared.
  - Records with no unit flags commit as soon as the output is free.
- Output register, 1 cycle after commit:
  - wbrf tvalid=1, rd=rd.
  - we = rd_vld && (rd != 0).
  - wdata selected by priority: sys.wdata if sys_cmd_vld, else bru.link if bru_cmd_vld, else the ALU result.
  - A beat is emitted for every committed record, including we=0 ones.
  - The beat is held stable until tready. tvalid clears on tready unless a new commit occurs in the same cycle (back-to-back throughput: 1/cycle).
- Redirect: on commit with (sys_cmd_vld && sys.redirect) or (bru_cmd_vld && bru.taken):
  - Next cycle: redirect_valid=1, invalidate=1, redirect_pc = sys.target if the sys redirect applies, else bru.target. SYS has priority when both apply.
  - Both pulses last exactly one cycle and coincide with the committing wbrf beat.
- Flush cycle (invalidate=1):
  - All slot valids are cleared at the end of the cycle.
  - All input treadys are 0 and no commit occurs.
  - The wbrf output register is untouched. The committed beat is still delivered and has already passed the retire point.
  - From the next cycle, normal operation resumes with empty slots.
- rst asserted mid-operation: all state returns to reset values on the next edge. A pending wbrf beat is dropped.
- Widths: no arithmetic in this block. link and target are computed by the BRU/SYS units.

Test Plan:
- ALU-only record (rd=5, rd_vld=1), ALU beat 0x0000_1234 one cycle before exwb valid, wbrf tready=1 -> wbrf beat {wdata=0x1234, rd=5, we=1} one cycle after commit; redirect_valid and invalidate stay 0.
- Record with rd=0, ALU result 0xFFFF_FFFF -> beat with we=0; exwb handshake completes.
- BRU record (rd=1) with taken=1, target=0x8000_0100, link=0x8000_0008 -> wbrf {0x8000_0008, rd=1, we=1} plus redirect_valid=1, redirect_pc=0x8000_0100, invalidate=1 for exactly one cycle. A younger ALU beat offered in that cycle sees tready=0, and the ALU slot is empty afterwards.
- SYS record with redirect=1, target=0x8000_0004, wdata=0x42 (rd=10) -> redirect_pc=0x8000_0004, wbrf wdata=0x42.
- Backpressure: hold wbrf tready=0 for 3 cycles with two ready ALU records queued -> first beat held stable, exwb tready=0, ALU tready=0 once the slot is full; on release, beats follow on consecutive cycles in order.
- Assert rst for 1 cycle while a BRU slot is valid and a wbrf beat is pending -> all outputs 0 next cycle; the slot is empty (a following BRU-flagged record does not commit until a new BRU beat arrives).
